// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// slave is the adder side, master is the side feeding operands and
// taking results.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s        : sum bit
//   co       : carry out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_addsub_segment.sv
// Combinational SEG-bit ripple-carry slice used by each pipeline stage.
//   a_seg, b_seg : operand slices (b_seg already inverted for subtract)
//   ci           : carry into the slice
//   s_seg        : sum slice
//   co           : carry out of the slice
//   c_msb        : carry into the top bit of the slice (for overflow)
module addsub_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           ci,
    output logic [SEG-1:0] s_seg,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        fulladder u_fa (
            .a  (a_seg[i]),
            .b  (b_seg[i]),
            .ci (c[i]),
            .s  (s_seg[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// segments; one beat per cycle, STAGES cycles of latency.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of pipelined_addsub_if
//              in:  in_valid, a, b, cin, sub, out_ready
//              out: in_ready, out_valid, sum, cout, ovf
// Stage k registers a mixed word: bits below (k+1)*SEG hold finished sum
// slices, bits above still hold operand A. The not-yet-consumed upper part
// of B' travels in a separate register that shrinks by SEG per stage.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_addsub_if.slave  bus
);

    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // The whole pipe freezes while a finished result waits downstream.
    logic stall;

    assign stall       = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SRCW = WIDTH - k * SEG;

        logic             src_v;
        logic [WIDTH-1:0] src_mix;
        logic [SRCW-1:0]  src_b;
        logic             src_c;

        logic [SEG-1:0]   s_seg;
        logic             co;
        logic             c_msb;
        logic [WIDTH-1:0] nxt_mix;

        logic             v_q;
        logic [WIDTH-1:0] mix_q;
        logic             c_q;

        if (k == 0) begin : g_src
            assign src_v   = bus.in_valid;
            assign src_mix = bus.a;
            assign src_b   = bus.sub ? ~bus.b : bus.b;
            assign src_c   = bus.sub ? 1'b1 : bus.cin;
        end else begin : g_src
            assign src_v   = g_stg[k-1].v_q;
            assign src_mix = g_stg[k-1].mix_q;
            assign src_b   = g_stg[k-1].g_mid.b_q;
            assign src_c   = g_stg[k-1].c_q;
        end

        addsub_segment #(
            .SEG (SEG)
        ) u_seg (
            .a_seg (src_mix[k*SEG +: SEG]),
            .b_seg (src_b[SEG-1:0]),
            .ci    (src_c),
            .s_seg (s_seg),
            .co    (co),
            .c_msb (c_msb)
        );

        // Replace the consumed A slice with its finished sum slice.
        always_comb begin
            nxt_mix                = src_mix;
            nxt_mix[k*SEG +: SEG]  = s_seg;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                mix_q <= '0;
                c_q   <= 1'b0;
            end else if (!stall) begin
                v_q   <= src_v;
                mix_q <= nxt_mix;
                c_q   <= co;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [SRCW-SEG-1:0] b_q;
            logic                unused_c_msb;

            assign unused_c_msb = c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (!stall) begin
                    b_q <= src_b[SRCW-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= c_msb ^ co;
                end
            end

            assign bus.out_valid = v_q;
            assign bus.sum       = mix_q;
            assign bus.cout      = c_q;
            assign bus.ovf       = ovf_q;
        end
    end

endmodule
